multi_channel_load_counter: RTL and testbench
=============================================

Name: multi_channel_load_counter

Overview:
- Parametrised successor to the single-channel instruction-FIFO load counter.
- Provides NUM_CHANNELS independent counters. Each channel has loadable start value, programmable step, terminal limit, up/down direction and wrap or saturate end behaviour.
- Used by the instruction FIFO and the address generators to sequence tile and row counts across multiple matrix streams.
- All outputs are registered. An optional input pipeline stage eases timing.

Parameters:
- COUNTER_WIDTH, 32, width of every count, start, step and limit value.
- NUM_CHANNELS, 4, number of independent counter channels.
- WRAP_MODE, 1. 1 = reload start value at terminal; 0 = saturate at limit and hold.
- PIPE_IN, 1. 1 = register all control/data inputs one cycle before use; 0 = use directly.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- enable  input  NUM_CHANNELS  per-channel count enable.
- load  input  NUM_CHANNELS  per-channel load strobe.
- clear  input  NUM_CHANNELS  per-channel clear to idle.
- dir  input  NUM_CHANNELS  per-channel direction, 0 = up, 1 = down; sampled with load.
- start_val  input  NUM_CHANNELS*COUNTER_WIDTH  per-channel load value (packed, channel 0 in LSBs).
- step  input  NUM_CHANNELS*COUNTER_WIDTH  per-channel increment; sampled with load.
- limit  input  NUM_CHANNELS*COUNTER_WIDTH  per-channel terminal value; sampled with load.
- count_val  output  NUM_CHANNELS*COUNTER_WIDTH  current count.
- terminal  output  NUM_CHANNELS  one-cycle pulse when the limit is reached or crossed.
- done  output  NUM_CHANNELS  level; saturated channel (WRAP_MODE=0 only).
- busy  output  NUM_CHANNELS  level; channel is in RUN.

Behaviour:
- Reset: rst_n=0 at a clock edge sets all channels to IDLE, with count_val=0, terminal=0, done=0, busy=0. The input pipe registers and the latched dir/step/limit/start are also cleared to 0. Reset wins over every other input, including mid-count.
- Input stage:
  - PIPE_IN=1: enable, load, clear, dir, start_val, step and limit are registered every cycle. The core sees them one cycle late.
  - PIPE_IN=0: the core sees them directly.
  - All latencies below are measured from the core-visible input. Add 1 cycle when PIPE_IN=1.
- Per-channel FSM:
  - States are IDLE, RUN and DONE.
  - Priority: clear > load > count.
- clear (any state): next state IDLE. count_val holds its value; terminal=0, done=0.
- load (any state, independent of enable):
  - count_val <= start_val on the next edge.
  - dir, step, limit and start_val are latched into shadow registers.
  - Next state is RUN and terminal=0.
- RUN & enable & !load & !clear: compute nxt in COUNTER_WIDTH+1 bits.
  - Up: nxt = count + step.
  - Down: nxt = count - step.
  - The limit is hit when:
    - Up: nxt >= limit, or the carry-out is set.
    - Down: count < step (borrow), or nxt <= limit.
  - No hit: count_val <= nxt truncated to COUNTER_WIDTH.
  - Hit with WRAP_MODE=1: count_val <= latched start_val, terminal pulses 1 for one cycle, and the channel stays in RUN.
  - Hit with WRAP_MODE=0: count_val <= limit, terminal pulses for one cycle, and the state goes to DONE with done=1.
- RUN & !enable: count_val holds and terminal=0.
- IDLE and DONE ignore enable. count_val holds. done stays 1 in DONE until load or clear.
- step=0 in RUN with enable: the count holds. The limit is hit only if count already meets the hit condition. With WRAP_MODE=1 this produces repeated terminal pulses on every enabled cycle.
- A start_val already beyond the limit is accepted. The first enabled RUN cycle then hits the limit.
- busy = (state == RUN). All outputs come directly from flops.
- Channels are fully independent; there is no cross-channel interaction.

Test Plan:
- Reset during count: run ch0 up to count 5, then assert rst_n=0 for 1 cycle. Expect count_val[0]=0, busy=0, terminal=0. With PIPE_IN=1, a subsequent load of 7 appears on count_val 2 cycles after it is presented.
- Up wrap: WRAP_MODE=1, PIPE_IN=0, ch1 load start=2, step=3, limit=10, dir=0, then enable continuously. Expect count sequence 2,5,8,2,5,… with terminal=1 exactly on the cycle count returns to 2.
- Down saturate: WRAP_MODE=0, ch2 load start=9, step=4, limit=0, dir=1, enable held. Expect 9,5,1,0. terminal pulses once with count 0, then done=1, busy=0, and count stays 0 while enable stays high.
- Priority and simultaneity: on one edge assert clear, load and enable on ch3. Expect IDLE with count held. Next, load+enable together with start=20: expect count=20 with no increment in the same cycle.
- Overflow: COUNTER_WIDTH=8, load start=250, step=10, limit=255, up, WRAP_MODE=1. Expect a carry-detected hit, terminal=1 and count=250, with no truncated value of 4 ever visible.
- Channel independence: ch0 and ch1 run different step/limit values with interleaved enables. Load ch1 mid-run and confirm ch0 is unaffected and ch1 restarts from its new start_val.

Source files
------------

// File: rtl/multi_channel_load_counter.sv
// multi_channel_load_counter: independent loadable up/down counters with wrap or saturate at a limit
module multi_channel_load_counter #(
    parameter int COUNTER_WIDTH = 32,
    parameter int NUM_CHANNELS  = 4,
    parameter bit WRAP_MODE     = 1,
    parameter bit PIPE_IN       = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_CHANNELS-1:0]               enable,
    input  logic [NUM_CHANNELS-1:0]               load,
    input  logic [NUM_CHANNELS-1:0]               clear,
    input  logic [NUM_CHANNELS-1:0]               dir,
    input  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] start_val,
    input  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] step,
    input  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] limit,
    output logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] count_val,
    output logic [NUM_CHANNELS-1:0]               terminal,
    output logic [NUM_CHANNELS-1:0]               done,
    output logic [NUM_CHANNELS-1:0]               busy
);
    localparam int W = COUNTER_WIDTH;
    localparam int N = NUM_CHANNELS;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    logic [N-1:0]   en_c, ld_c, clr_c, dir_c;
    logic [N*W-1:0] start_c, step_c, limit_c;
    if (PIPE_IN) begin : g_pipe
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                en_c    <= '0;
                ld_c    <= '0;
                clr_c   <= '0;
                dir_c   <= '0;
                start_c <= '0;
                step_c  <= '0;
                limit_c <= '0;
            end else begin
                en_c    <= enable;
                ld_c    <= load;
                clr_c   <= clear;
                dir_c   <= dir;
                start_c <= start_val;
                step_c  <= step;
                limit_c <= limit;
            end
        end
    end else begin : g_direct
        assign en_c    = enable;
        assign ld_c    = load;
        assign clr_c   = clear;
        assign dir_c   = dir;
        assign start_c = start_val;
        assign step_c  = step;
        assign limit_c = limit;
    end
    for (genvar c = 0; c < N; c++) begin : g_ch
        state_t       state;
        logic         sh_dir, term, dn, bsy, hit;
        logic [W-1:0] sh_step, sh_limit, sh_start, cnt;
        logic [W:0]   nxt;
        // nxt carries one extra bit so an up-count carry shows up as exceeding any limit
        always_comb begin
            nxt = sh_dir ? {1'b0, cnt} - {1'b0, sh_step} : {1'b0, cnt} + {1'b0, sh_step};
            hit = sh_dir ? (cnt < sh_step) || (nxt[W-1:0] <= sh_limit) : (nxt >= {1'b0, sh_limit});
        end
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state    <= IDLE;
                cnt      <= '0;
                term     <= 1'b0;
                dn       <= 1'b0;
                bsy      <= 1'b0;
                sh_dir   <= 1'b0;
                sh_step  <= '0;
                sh_limit <= '0;
                sh_start <= '0;
            end else if (clr_c[c]) begin
                state <= IDLE;
                term  <= 1'b0;
                dn    <= 1'b0;
                bsy   <= 1'b0;
            end else if (ld_c[c]) begin
                state    <= RUN;
                cnt      <= start_c[c*W +: W];
                term     <= 1'b0;
                dn       <= 1'b0;
                bsy      <= 1'b1;
                sh_dir   <= dir_c[c];
                sh_step  <= step_c[c*W +: W];
                sh_limit <= limit_c[c*W +: W];
                sh_start <= start_c[c*W +: W];
            end else if (state == RUN && en_c[c]) begin
                term <= hit;
                if (!hit) begin
                    cnt <= nxt[W-1:0];
                end else if (WRAP_MODE) begin
                    cnt <= sh_start;
                end else begin
                    cnt   <= sh_limit;
                    state <= DONE;
                    dn    <= 1'b1;
                    bsy   <= 1'b0;
                end
            end else begin
                term <= 1'b0;
            end
        end
        assign count_val[c*W +: W] = cnt;
        assign terminal[c]         = term;
        assign done[c]             = dn;
        assign busy[c]             = bsy;
    end
endmodule

// File: tb/tb_multi_channel_load_counter.sv
// tb_multi_channel_load_counter: three configurations driven in parallel against an arithmetic reference model
module tb_multi_channel_load_counter;
    localparam int W = 8;
    localparam int N = 4;
    localparam int M = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]   enable = '0, load = '0, clear = '0, dir = '0;
    logic [N*W-1:0] start_val = '0, step = '0, limit = '0;
    logic [N*W-1:0] cv [M];
    logic [N-1:0]   tm [M], dn [M], bz [M];
    int n_cmp = 0, n_err = 0;
    // model: 0 idle, 1 run, 2 done
    int m_st [M][N], m_cnt [M][N], m_term [M][N], m_done [M][N];
    int s_dir [M][N], s_step [M][N], s_lim [M][N], s_start [M][N];
    logic [N-1:0]   p_en = '0, p_ld = '0, p_clr = '0, p_dir = '0;
    logic [N*W-1:0] p_st = '0, p_sp = '0, p_lm = '0;
    always #5 clk = ~clk;
    // u0: wrap + input pipe, u1: saturate direct, u2: wrap direct
    multi_channel_load_counter #(.COUNTER_WIDTH(W), .NUM_CHANNELS(N), .WRAP_MODE(1), .PIPE_IN(1)) u_wrap_pipe (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .clear(clear), .dir(dir),
        .start_val(start_val), .step(step), .limit(limit),
        .count_val(cv[0]), .terminal(tm[0]), .done(dn[0]), .busy(bz[0]));
    multi_channel_load_counter #(.COUNTER_WIDTH(W), .NUM_CHANNELS(N), .WRAP_MODE(0), .PIPE_IN(0)) u_sat_direct (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .clear(clear), .dir(dir),
        .start_val(start_val), .step(step), .limit(limit),
        .count_val(cv[1]), .terminal(tm[1]), .done(dn[1]), .busy(bz[1]));
    multi_channel_load_counter #(.COUNTER_WIDTH(W), .NUM_CHANNELS(N), .WRAP_MODE(1), .PIPE_IN(0)) u_wrap_direct (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .clear(clear), .dir(dir),
        .start_val(start_val), .step(step), .limit(limit),
        .count_val(cv[2]), .terminal(tm[2]), .done(dn[2]), .busy(bz[2]));

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < M; m++) begin
            bit wrap = (m != 1);
            bit pipe = (m == 0);
            for (int c = 0; c < N; c++) begin
                bit e  = pipe ? p_en[c]  : enable[c];
                bit l  = pipe ? p_ld[c]  : load[c];
                bit cl = pipe ? p_clr[c] : clear[c];
                bit d  = pipe ? p_dir[c] : dir[c];
                int sv = int'(pipe ? p_st[c*W +: W] : start_val[c*W +: W]);
                int sp = int'(pipe ? p_sp[c*W +: W] : step[c*W +: W]);
                int lm = int'(pipe ? p_lm[c*W +: W] : limit[c*W +: W]);
                if (!rst_n) begin
                    m_st[m][c] = 0; m_cnt[m][c] = 0; m_term[m][c] = 0; m_done[m][c] = 0;
                    s_dir[m][c] = 0; s_step[m][c] = 0; s_lim[m][c] = 0; s_start[m][c] = 0;
                end else if (cl) begin
                    m_st[m][c] = 0; m_term[m][c] = 0; m_done[m][c] = 0;
                end else if (l) begin
                    m_cnt[m][c] = sv; m_st[m][c] = 1; m_term[m][c] = 0; m_done[m][c] = 0;
                    s_dir[m][c] = int'(d); s_step[m][c] = sp; s_lim[m][c] = lm; s_start[m][c] = sv;
                end else if (m_st[m][c] == 1 && e) begin
                    int s = s_dir[m][c] != 0 ? m_cnt[m][c] - s_step[m][c] : m_cnt[m][c] + s_step[m][c];
                    bit h = s_dir[m][c] != 0 ? (s <= s_lim[m][c]) : (s >= s_lim[m][c]);
                    m_term[m][c] = int'(h);
                    if (!h) m_cnt[m][c] = s;
                    else if (wrap) m_cnt[m][c] = s_start[m][c];
                    else begin
                        m_cnt[m][c] = s_lim[m][c]; m_st[m][c] = 2; m_done[m][c] = 1;
                    end
                end else begin
                    m_term[m][c] = 0;
                end
            end
        end
        if (!rst_n) begin
            p_en = '0; p_ld = '0; p_clr = '0; p_dir = '0; p_st = '0; p_sp = '0; p_lm = '0;
        end else begin
            p_en = enable; p_ld = load; p_clr = clear; p_dir = dir;
            p_st = start_val; p_sp = step; p_lm = limit;
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < M; m++)
            for (int c = 0; c < N; c++) begin
                chk($sformatf("u%0d.ch%0d.count", m, c), int'(cv[m][c*W +: W]), m_cnt[m][c]);
                chk($sformatf("u%0d.ch%0d.terminal", m, c), int'(tm[m][c]), m_term[m][c]);
                chk($sformatf("u%0d.ch%0d.done", m, c), int'(dn[m][c]), m_done[m][c]);
                chk($sformatf("u%0d.ch%0d.busy", m, c), int'(bz[m][c]), int'(m_st[m][c] == 1));
            end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic cfg(input int c, input int sv, input int sp, input int lm, input bit d);
        start_val[c*W +: W] = W'(sv);
        step[c*W +: W]      = W'(sp);
        limit[c*W +: W]     = W'(lm);
        dir[c]              = d;
    endtask

    function automatic int cnt_of(input int m, input int c);
        return int'(cv[m][c*W +: W]);
    endfunction

    initial begin
        for (int m = 0; m < M; m++)
            for (int c = 0; c < N; c++) begin
                m_st[m][c] = 0; m_cnt[m][c] = 0; m_term[m][c] = 0; m_done[m][c] = 0;
                s_dir[m][c] = 0; s_step[m][c] = 0; s_lim[m][c] = 0; s_start[m][c] = 0;
            end
        @(negedge clk);
        cyc(2);
        chk("reset.count_all", int'(cv[0]), 0);
        chk("reset.busy_all", int'(bz[0] | bz[1] | bz[2]), 0);
        rst_n = 1'b1;
        // reset mid-count, then a load through the input pipe
        cfg(0, 0, 1, 200, 1'b0); load[0] = 1'b1; enable[0] = 1'b1;
        cyc(1);
        load[0] = 1'b0;
        for (int i = 0; i < 20 && m_cnt[0][0] != 5; i++) cyc(1);
        chk("rst.reached5", cnt_of(0, 0), 5);
        rst_n = 1'b0;
        cyc(1);
        chk("rst.count", cnt_of(0, 0), 0);
        chk("rst.busy", int'(bz[0][0]), 0);
        chk("rst.terminal", int'(tm[0][0]), 0);
        rst_n = 1'b1; enable[0] = 1'b0; cfg(0, 7, 1, 200, 1'b0); load[0] = 1'b1;
        cyc(1);
        load[0] = 1'b0;
        chk("pipe.load_lat1", cnt_of(0, 0), 0);
        cyc(1);
        chk("pipe.load_lat2", cnt_of(0, 0), 7);
        // up wrap on ch1
        cfg(1, 2, 3, 10, 1'b0); load[1] = 1'b1; enable[1] = 1'b1;
        cyc(1);
        load[1] = 1'b0;
        chk("wrap.s0", cnt_of(2, 1), 2);
        cyc(1); chk("wrap.s1", cnt_of(2, 1), 5);
        cyc(1); chk("wrap.s2", cnt_of(2, 1), 8);
        cyc(1); chk("wrap.s3", cnt_of(2, 1), 2); chk("wrap.term", int'(tm[2][1]), 1);
        cyc(1); chk("wrap.s4", cnt_of(2, 1), 5); chk("wrap.term_off", int'(tm[2][1]), 0);
        enable[1] = 1'b0;
        // down saturate on ch2
        cfg(2, 9, 4, 0, 1'b1); load[2] = 1'b1; enable[2] = 1'b1;
        cyc(1);
        load[2] = 1'b0;
        chk("sat.s0", cnt_of(1, 2), 9);
        cyc(1); chk("sat.s1", cnt_of(1, 2), 5);
        cyc(1); chk("sat.s2", cnt_of(1, 2), 1);
        cyc(1); chk("sat.s3", cnt_of(1, 2), 0); chk("sat.term", int'(tm[1][2]), 1);
        chk("sat.done", int'(dn[1][2]), 1); chk("sat.busy", int'(bz[1][2]), 0);
        cyc(2); chk("sat.hold", cnt_of(1, 2), 0); chk("sat.term_once", int'(tm[1][2]), 0);
        chk("sat.done_held", int'(dn[1][2]), 1);
        enable[2] = 1'b0;
        // priority on ch3
        cfg(3, 3, 1, 50, 1'b0); load[3] = 1'b1; enable[3] = 1'b1;
        cyc(1);
        load[3] = 1'b0;
        cyc(2); chk("prio.pre", cnt_of(2, 3), 5);
        clear[3] = 1'b1; load[3] = 1'b1;
        cyc(1);
        chk("prio.clear_hold", cnt_of(2, 3), 5); chk("prio.idle", int'(bz[2][3]), 0);
        clear[3] = 1'b0; cfg(3, 20, 1, 50, 1'b0);
        cyc(1);
        load[3] = 1'b0;
        chk("prio.load_no_inc", cnt_of(2, 3), 20);
        cyc(1); chk("prio.count", cnt_of(2, 3), 21);
        enable[3] = 1'b0;
        // overflow on ch0
        cfg(0, 250, 10, 255, 1'b0); load[0] = 1'b1; enable[0] = 1'b1;
        cyc(1);
        load[0] = 1'b0;
        cyc(1); chk("ovf.count", cnt_of(2, 0), 250); chk("ovf.term", int'(tm[2][0]), 1);
        cyc(1); chk("ovf.again", cnt_of(2, 0), 250);
        // independence: ch1 reloaded while ch0 keeps counting
        cfg(0, 0, 2, 100, 1'b0); cfg(1, 0, 3, 100, 1'b0); load[1:0] = 2'b11;
        cyc(1);
        load[1:0] = 2'b00;
        for (int i = 0; i < 6; i++) begin enable[1:0] = 2'(i % 3 + 1); cyc(1); end
        cfg(1, 50, 3, 100, 1'b0); load[1] = 1'b1; enable[1:0] = 2'b11;
        cyc(1);
        load[1] = 1'b0;
        chk("indep.ch1", cnt_of(2, 1), 50);
        chk("indep.ch0", cnt_of(2, 0), m_cnt[2][0]);
        cyc(3);
        // randomized phase
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int c = 0; c < N; c++) begin
                enable[c] = ($urandom_range(0, 3) != 0);
                load[c]   = ($urandom_range(0, 9) == 0);
                clear[c]  = ($urandom_range(0, 24) == 0);
                cfg(c, int'($urandom_range(0, 255)),
                    $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end
            cyc(1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
